alu_rr_sched: RTL

- Round-robin scheduler that shares one N-bit, 8-operation ALU among NREQ requesters.
- Each requester presents {a, b, sel} under a valid/ready handshake.
- The scheduler grants one requester per cycle, drives the shared ALU, and registers the result into a single-entry response register tagged with the requester id.
- Sits between the operand-issuing units and their common result consumer.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu.sv | 40 ++++
 rtl/rr_arbiter.sv | 33 +++
 rtl/alu_rr_sched.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding and response-register state encoding.
// No ports: types only, imported by the ALU, arbiter users and the scheduler top.
// Opcode values are fixed by the requester interface and must not be reordered.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_INR = 3'b010,
    OP_DCR = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_CMP = 3'b111
  } alu_op_t;

  // The response register is either empty or holding one result.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_t;

endpackage

// File: rtl/alu.sv
// Purpose: combinational n-bit, 8-operation ALU with carry/borrow out.
// Ports: i_a/i_b operands, i_sel opcode (alu_op_t) -> o_s result, o_co carry/borrow.
// Latency 0 (purely combinational); no flow control of its own.
module alu
  import alu_pkg::*;
#(
  parameter int n = 4
) (
  input  logic [n-1:0] i_a,
  input  logic [n-1:0] i_b,
  input  logic [2:0]   i_sel,
  output logic [n-1:0] o_s,
  output logic         o_co
);

  localparam logic [n:0] ONE = {{n{1'b0}}, 1'b1};

  logic [n:0] w_res;

  // Everything is computed at n+1 bits so bit n is the carry (add) or the
  // borrow (subtract); logic ops leave bit n clear.
  always_comb begin
    w_res = '0;
    case (alu_op_t'(i_sel))
      OP_ADD:  w_res = {1'b0, i_a} + {1'b0, i_b};
      OP_SUB:  w_res = {1'b0, i_a} - {1'b0, i_b};
      OP_INR:  w_res = {1'b0, i_a} + ONE;
      OP_DCR:  w_res = {1'b0, i_a} - ONE;
      OP_AND:  w_res = {1'b0, i_a & i_b};
      OP_OR:   w_res = {1'b0, i_a | i_b};
      OP_XOR:  w_res = {1'b0, i_a ^ i_b};
      OP_CMP:  w_res = {1'b0, ~i_b};
      default: w_res = '0;
    endcase
  end

  assign o_s  = w_res[n-1:0];
  assign o_co = w_res[n];

endmodule

// File: rtl/rr_arbiter.sv
// Purpose: combinational round-robin arbiter, search starts just after i_ptr.
// Ports: i_req request vector, i_ptr last winner -> o_gnt one-hot, o_idx binary, o_any.
// Latency 0; the caller owns the pointer register and any ready gating.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic w_found;

  // Visit ptr+1 .. ptr+NREQ (mod NREQ); the last slot visited is ptr itself,
  // so the previous winner has lowest priority.
  always_comb begin
    w_found = 1'b0;
    o_gnt   = '0;
    o_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && i_req[(int'(i_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        o_idx   = IDW'((int'(i_ptr) + k) % NREQ);
        o_gnt[(int'(i_ptr) + k) % NREQ] = 1'b1;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Purpose: round-robin sharing of one ALU among NREQ requesters; result registered with requester id.
// Ports: req_valid/req_ready + packed req_a/req_b/req_sel in; rsp_valid/rsp_ready, rsp_id/s/co, ops_count out.
// Latency 1 cycle accept->rsp_valid; req_ready drops to 0 while the response is held and not drained.
module alu_rr_sched
  import alu_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int NREQ = 4,
  parameter  int CNTW = 16,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ*3-1:0] req_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_s,
  output logic              rsp_co,
  output logic [CNTW-1:0]   ops_count
);

  rsp_state_t      r_state;
  rsp_state_t      w_state_nxt;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_rsp_id;
  logic [N-1:0]    r_rsp_s;
  logic            r_rsp_co;
  logic [CNTW-1:0] r_ops_count;

  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_gnt_idx;
  logic            w_any;
  logic            w_can_load;
  logic            w_accept;
  logic            w_drain;
  logic [N-1:0]    w_a;
  logic [N-1:0]    w_b;
  logic [2:0]      w_sel;
  logic [N-1:0]    w_s;
  logic            w_co;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx),
    .o_any (w_any)
  );

  // Operand mux driven by the arbiter's binary index.
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_idx == IDW'(i)) begin
        w_a   = req_a[i*N +: N];
        w_b   = req_b[i*N +: N];
        w_sel = req_sel[i*3 +: 3];
      end
    end
  end

  alu #(
    .n (N)
  ) u_alu (
    .i_a   (w_a),
    .i_b   (w_b),
    .i_sel (w_sel),
    .o_s   (w_s),
    .o_co  (w_co)
  );

  // The register can take a new result when empty, or when it is being
  // drained this same cycle (back-to-back, no bubble).
  assign w_can_load = (r_state == ST_EMPTY) | rsp_ready;
  assign req_ready  = (!rst && w_can_load && w_any) ? w_gnt : '0;
  assign w_accept   = |(req_valid & req_ready);
  assign w_drain    = (r_state == ST_FULL) & rsp_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL: begin
        if (w_accept)       w_state_nxt = ST_FULL;
        else if (rsp_ready) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Response payload, round-robin pointer and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= IDW'(NREQ - 1);
      r_rsp_id    <= '0;
      r_rsp_s     <= '0;
      r_rsp_co    <= 1'b0;
      r_ops_count <= '0;
    end else begin
      if (w_accept) begin
        r_rsp_s  <= w_s;
        r_rsp_co <= w_co;
        r_rsp_id <= w_gnt_idx;
        r_ptr    <= w_gnt_idx;
      end
      if (w_drain) begin
        r_ops_count <= r_ops_count + CNTW'(1);
      end
    end
  end

  // Output logic
  always_comb begin
    rsp_valid = (r_state == ST_FULL);
    rsp_id    = r_rsp_id;
    rsp_s     = r_rsp_s;
    rsp_co    = r_rsp_co;
    ops_count = r_ops_count;
  end

endmodule
